// File: rtl/cpu_debug_scanner_pkg.sv
// Shared definitions for the CPU debug-port scanner: record kinds,
// scan FSM state type and register-file size.
package cpu_debug_pkg;

  localparam logic [1:0] KIND_PC   = 2'd0;
  localparam logic [1:0] KIND_INST = 2'd1;
  localparam logic [1:0] KIND_RF   = 2'd2;
  localparam logic [1:0] KIND_MEM  = 2'd3;

  localparam int RF_COUNT = 32;

  typedef enum logic [3:0] {
    IDLE,
    SNAP,
    EMIT_PC,
    EMIT_INST,
    RF_SET,
    RF_WAIT,
    RF_EMIT,
    MEM_SET,
    MEM_WAIT,
    MEM_EMIT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/cpu_debug_scanner_rec_reg.sv
// One-entry output record register: a loaded record stays valid and
// unchanged until the consumer accepts it.
module debug_rec_reg
  import cpu_debug_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [1:0]  kind_i,
  input  logic [7:0]  index_i,
  input  logic [31:0] data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [1:0]  kind_o,
  output logic [7:0]  index_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [1:0]  kind_q, kind_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] data_q, data_d;

  // Load wins over acceptance so back-to-back records keep valid high.
  always_comb begin
    kind_d  = kind_q;
    index_d = index_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      kind_d  = kind_i;
      index_d = index_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      kind_q  <= 2'd0;
      index_q <= 8'd0;
      data_q  <= 32'd0;
    end else begin
      valid_q <= valid_d;
      kind_q  <= kind_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign kind_o  = kind_q;
  assign index_o = index_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cpu_debug_scanner.sv
// Debug-port scanner: dumps PC, INST, r0..r31 and a memory window as tagged
// records on a valid/ready stream. Optional SCAN_SKIP_ZERO_EN drops zero RF/MEM words.
module cpu_debug_scanner
  import cpu_debug_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [7:0]  out_index,
  output logic [31:0] out_data
);

  scan_state_e state_q, state_d, adv_state_s, smp_state_s;
  logic [7:0]  idx_q, idx_d, adv_idx_s, smp_idx_s;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] inst_q, inst_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        load_s, hs_s, in_rf_s, skip_s, last_s;
  logic [1:0]  ld_kind_s;
  logic [7:0]  ld_index_s;
  logic [31:0] ld_data_s, sample_data_s;

  assign hs_s          = out_valid && out_ready;
  assign in_rf_s       = (state_q == RF_SET) || (state_q == RF_WAIT) || (state_q == RF_EMIT);
  assign sample_data_s = in_rf_s ? rf_data : mem_data;

`ifdef SCAN_SKIP_ZERO_EN
  assign skip_s = (sample_data_s == 32'h0);
`else
  assign skip_s = 1'b0;
`endif

  // Where the scan goes after the current index, and where a sample lands.
  always_comb begin
    if (in_rf_s) begin
      last_s = (idx_q == 8'(RF_COUNT - 1));
    end else begin
      last_s = (idx_q == 8'(MEM_WORDS - 1));
    end
    if (last_s) begin
      adv_state_s = in_rf_s ? MEM_SET : DONE;
      adv_idx_s   = 8'd0;
    end else begin
      adv_state_s = in_rf_s ? RF_SET : MEM_SET;
      adv_idx_s   = idx_q + 8'd1;
    end
    smp_state_s = skip_s ? adv_state_s : (in_rf_s ? RF_EMIT : MEM_EMIT);
    smp_idx_s   = skip_s ? adv_idx_s : idx_q;
  end

  // Next-state, record load and address drive.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    inst_d     = inst_q;
    load_s     = 1'b0;
    ld_kind_s  = in_rf_s ? KIND_RF : KIND_MEM;
    ld_index_s = idx_q;
    ld_data_s  = sample_data_s;
    case (state_q)
      IDLE: begin
        if (start) state_d = SNAP;
        else       state_d = IDLE;
      end
      SNAP: begin
        inst_d     = cpu_inst;
        load_s     = 1'b1;
        ld_kind_s  = KIND_PC;
        ld_index_s = 8'd0;
        ld_data_s  = cpu_pc;
        state_d    = EMIT_PC;
      end
      EMIT_PC: begin
        if (hs_s) begin
          load_s     = 1'b1;
          ld_kind_s  = KIND_INST;
          ld_index_s = 8'd0;
          ld_data_s  = inst_q;
          state_d    = EMIT_INST;
        end else begin
          state_d = EMIT_PC;
        end
      end
      EMIT_INST: begin
        if (hs_s) begin
          state_d = RF_SET;
          idx_d   = 8'd0;
        end else begin
          state_d = EMIT_INST;
        end
      end
      RF_SET, MEM_SET: begin
        if (RD_LAT == 32'd1) begin
          state_d = smp_state_s;
          idx_d   = smp_idx_s;
          load_s  = !skip_s;
        end else begin
          wait_d  = 3'(RD_LAT - 32'd2);
          state_d = in_rf_s ? RF_WAIT : MEM_WAIT;
        end
      end
      RF_WAIT, MEM_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = smp_state_s;
          idx_d   = smp_idx_s;
          load_s  = !skip_s;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RF_EMIT, MEM_EMIT: begin
        if (hs_s) begin
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rf_addr_d  = (state_d == RF_SET) ? idx_d[4:0] : rf_addr_q;
    mem_addr_d = (state_d == MEM_SET) ? (MEM_BASE + {22'd0, idx_d, 2'b00}) : mem_addr_q;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      wait_q     <= 3'd0;
      inst_q     <= 32'd0;
      rf_addr_q  <= 5'd0;
      mem_addr_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      inst_q     <= inst_d;
      rf_addr_q  <= rf_addr_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  debug_rec_reg u_rec (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load_s),
    .kind_i  (ld_kind_s),
    .index_i (ld_index_s),
    .data_i  (ld_data_s),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .kind_o  (out_kind),
    .index_o (out_index),
    .data_o  (out_data)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rf_addr  = rf_addr_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: doc/cpu_debug_scanner.md
Name: cpu_debug_scanner

Overview:
Reads the single-cycle CPU's debug port from the consumer side. It drives rf_addr and mem_addr, samples rf_data, mem_data, cpu_pc and cpu_inst, and emits one tagged 32-bit record per value on a valid/ready stream. The stream feeds the board's display/UART formatter, so a full architectural dump (PC, INST, r0..r31, memory window) needs only a single start pulse.

Parameters:
MEM_WORDS, 32, number of memory words dumped (1..256).
MEM_BASE, 32'h0000_0000, byte address of the first dumped word (word-aligned).
RD_LAT, 1, cycles from address drive to data sample (1..4).

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a dump; ignored while busy.
busy  out  1  high from the cycle after an accepted start through the done cycle.
done  out  1  one-cycle pulse after the last record handshakes.
rf_addr  out  5  register index to CPU debug port.
mem_addr  out  32  byte address to CPU debug port.
rf_data  in  32  register value for rf_addr.
mem_data  in  32  memory word for mem_addr.
cpu_pc  in  32  current PC.
cpu_inst  in  32  current instruction.
out_valid  out  1  record available.
out_ready  in  1  consumer accepts the record when out_valid and out_ready are both high.
out_kind  out  2  record type: 0=PC, 1=INST, 2=RF, 3=MEM.
out_index  out  8  register number or memory word index (0 for PC/INST).
out_data  out  32  record payload.

Behaviour:
- This block has one clock, clk. Reset is resetn, asynchronous and active-low.
- Reset: all outputs are 0 and the FSM is in IDLE. Reset asserted mid-dump aborts immediately; no done pulse is issued.
- FSM states: IDLE -> SNAP -> EMIT_PC -> EMIT_INST -> RF_SET -> RF_WAIT -> RF_EMIT -> (loop RF_SET until index 31) -> MEM_SET -> MEM_WAIT -> MEM_EMIT -> (loop until index MEM_WORDS-1) -> DONE -> IDLE.
- IDLE: when start=1, go to SNAP. busy rises the next cycle.
- SNAP: captures cpu_pc and cpu_inst in the same cycle, so PC and INST are a coherent pair.
- RF_SET / MEM_SET: drive the address.
  - rf_addr = i.
  - mem_addr = MEM_BASE + 4*i, 32-bit wrapping add.
- WAIT: lasts RD_LAT-1 cycles; skipped when RD_LAT=1. Data is sampled RD_LAT cycles after the address is driven.
- Addresses hold their last value while a record stalls, and after the dump until the next start.
- Emit states: out_valid=1. out_kind, out_index and out_data are stable while out_valid=1 and out_ready=0. The FSM advances on the handshake cycle.
- out_valid may not rise before the corresponding sample is registered. No combinational path from out_ready to out_valid.
- Throughput with out_ready tied high and RD_LAT=1: one record per 2 cycles for RF/MEM; the PC and INST records take 1 cycle each.
- Default record count is 2+32+MEM_WORDS = 66. Indices never wrap within a dump.
- DONE: done=1 for exactly one cycle, busy falls the following cycle.
- start asserted on the same cycle as done is ignored. A new start is accepted from IDLE only.

Optional Feature:
SCAN_SKIP_ZERO_EN
- Defined: RF and MEM records whose sampled data is 32'h0 are not emitted. The FSM goes straight to the next index with no handshake. PC/INST are always emitted. If every word is zero, the output is PC, INST, then done.
- Undefined: every record is emitted; the count is always 2+32+MEM_WORDS.

Decomposition:
- Package cpu_debug_pkg holds:
  - record-kind constants KIND_PC=0, KIND_INST=1, KIND_RF=2, KIND_MEM=3;
  - the state enum typedef;
  - the RF_COUNT=32 constant.
- Sub-module debug_rec_reg is a one-entry output register implementing the valid/ready hold rule. It is instantiated once.

Test Plan:
1. Reset then start with out_ready=1, cpu_pc=32'h0000_0034, cpu_inst=32'h2402_0005 -> PC and INST records carry those values, followed by 32 RF and 32 MEM records; done asserts once; total 66 handshakes.
2. Model mem_data = mem_addr ^ 32'hA5A5_A5A5, MEM_BASE=32'h100 -> MEM record i has index i and data (32'h100+4i) ^ 32'hA5A5_A5A5.
3. Random out_ready (~30% duty) -> no record dropped or duplicated, and payload is stable during every stall.
4. resetn low during the RF phase at index 17 -> all outputs read 0 immediately; done never pulses; a later start yields a full clean dump.
5. start pulsed while busy, and on the done cycle -> ignored; exactly one dump occurs.
6. With SCAN_SKIP_ZERO_EN and only r0=0 and r3=7 in the RF (others nonzero) -> no RF record with index 0; all other RF records appear; zero-valued MEM words are skipped.
